// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int DATA_W_DEFAULT = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_t;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CALC = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  function automatic logic is_div_op(input op_t op);
    return op[2];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide on unsigned magnitudes.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              is_div,
  input  logic [DATA_W-1:0] hi,
  input  logic [DATA_W-1:0] lo,
  input  logic [DATA_W-1:0] operand,
  output logic [DATA_W-1:0] hi_nxt,
  output logic [DATA_W-1:0] lo_nxt
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] shifted;
  logic [DATA_W:0] diff;

  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, operand} : '0);
    shifted = {hi, lo[DATA_W-1]};
    // remainder is always below the divisor, so diff's top bit is a clean borrow flag
    diff    = shifted - {1'b0, operand};
    hi_nxt  = '0;
    lo_nxt  = '0;
    if (is_div) begin
      if (!diff[DATA_W]) begin
        hi_nxt = diff[DATA_W-1:0];
        lo_nxt = {lo[DATA_W-2:0], 1'b1};
      end else begin
        hi_nxt = shifted[DATA_W-1:0];
        lo_nxt = {lo[DATA_W-2:0], 1'b0};
      end
    end else begin
      hi_nxt = sum[DATA_W:1];
      lo_nxt = {sum[0], lo[DATA_W-1:1]};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M-style multiply/divide unit: one step per clock, sign fix-up on completion.
//   state   | meaning
//   IDLE    | waiting for start; operands latched on start
//   CALC    | DATA_W iterations, then one edge to register the signed result
//   DONE    | done pulse, result valid; returns to IDLE
module mul_div_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        Funct3,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  state_t            state;
  op_t               op_q;
  logic [DATA_W-1:0] opnd;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;
  logic              neg_res;
  logic [CNT_W-1:0]  count;

  op_t               op_in;
  logic              sa;
  logic              sb;
  logic [DATA_W-1:0] abs_a;
  logic [DATA_W-1:0] abs_b;
  logic              neg_in;
  logic              div_zero;
  logic              div_ovf;
  logic [DATA_W-1:0] special_res;

  logic [DATA_W-1:0]   hi_nxt;
  logic [DATA_W-1:0]   lo_nxt;
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0]   final_res;

  always_comb begin
    op_in = op_t'(Funct3);
    sa    = op_a[DATA_W-1] & (op_in == OP_MULH || op_in == OP_MULHSU ||
                              op_in == OP_DIV  || op_in == OP_REM);
    sb    = op_b[DATA_W-1] & (op_in == OP_MULH || op_in == OP_DIV || op_in == OP_REM);
    abs_a = sa ? -op_a : op_a;
    abs_b = sb ? -op_b : op_b;
    // remainder follows the dividend sign; products and quotients follow the XOR
    neg_in   = (op_in == OP_REM) ? sa : (sa ^ sb);
    div_zero = is_div_op(op_in) && (op_b == '0);
    div_ovf  = (op_in == OP_DIV || op_in == OP_REM) &&
               (op_a == {1'b1, {(DATA_W-1){1'b0}}}) && (op_b == '1);
    special_res = '0;
    if (div_zero) begin
      special_res = (op_in == OP_DIV || op_in == OP_DIVU) ? '1 : op_a;
    end else if (div_ovf) begin
      special_res = (op_in == OP_DIV) ? op_a : '0;
    end
  end

  muldiv_step #(.DATA_W(DATA_W)) u_step (
    .is_div  (is_div_op(op_q)),
    .hi      (hi),
    .lo      (lo),
    .operand (opnd),
    .hi_nxt  (hi_nxt),
    .lo_nxt  (lo_nxt)
  );

  always_comb begin
    prod_fix  = neg_res ? -{hi, lo} : {hi, lo};
    final_res = '0;
    case (op_q)
      OP_MUL:                     final_res = prod_fix[DATA_W-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_fix[2*DATA_W-1:DATA_W];
      OP_DIV, OP_DIVU:            final_res = neg_res ? -lo : lo;
      OP_REM, OP_REMU:            final_res = neg_res ? -hi : hi;
      default:                    final_res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      op_q    <= OP_MUL;
      opnd    <= '0;
      hi      <= '0;
      lo      <= '0;
      neg_res <= 1'b0;
      count   <= '0;
      result  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && !flush) begin
            op_q    <= op_in;
            neg_res <= neg_in;
            count   <= '0;
            hi      <= '0;
            if (is_div_op(op_in)) begin
              lo   <= abs_a;
              opnd <= abs_b;
            end else begin
              lo   <= abs_b;
              opnd <= abs_a;
            end
            if (div_zero || div_ovf) begin
              result <= special_res;
              state  <= ST_DONE;
            end else begin
              state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (flush) begin
            state <= ST_IDLE;
          end else if (count == CNT_W'(DATA_W)) begin
            result <= final_res;
            state  <= ST_DONE;
          end else begin
            hi    <= hi_nxt;
            lo    <= lo_nxt;
            count <= count + CNT_W'(1);
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit at DATA_W=32.
module tb_mul_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  Funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  mul_div_unit #(.DATA_W(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .Funct3 (Funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // edges counts posedges from the start-sampling edge up to the one after which done is seen
  task automatic run(input string tag, input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp, input int lat,
                     input int inj, input bit redo);
    int edges;
    bit busy_all;
    Funct3 = f; op_a = a; op_b = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op_a = ~a; op_b = ~b;
    edges = 1; busy_all = 1'b1;
    while (!done && edges < 100) begin
      busy_all &= busy;
      if (edges == inj) begin
        start = 1'b1; Funct3 = 3'b000; op_a = 32'd7; op_b = 32'hFFFF_FFFD;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      edges++;
    end
    start = 1'b0;
    busy_all &= busy;
    chk({tag, "_result"}, {32'd0, result}, {32'd0, exp});
    chk({tag, "_latency"}, 64'(edges), 64'(lat));
    chk({tag, "_busy"}, {63'd0, busy_all}, 64'd1);
    if (redo) begin
      start = 1'b1; Funct3 = f; op_a = a; op_b = b;
    end
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
    chk({tag, "_idle"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_done;
    reset = 1'b1; start = 1'b0; flush = 1'b0; Funct3 = 3'b000; op_a = '0; op_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_result", {32'd0, result}, 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    run("mul",      3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 0, 0);
    run("mul_m1",   3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 34, 0, 0);
    run("mulh",     3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, 0, 0);
    run("mulh_m1",  3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34, 0, 0);
    run("mulhu",    3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 0, 0);
    run("mulhsu",   3'b010, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 34, 0, 0);
    run("div",      3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34, 0, 0);
    run("rem",      3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34, 0, 0);
    run("div_nb",   3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, 0, 0);
    run("rem_nb",   3'b110, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 34, 0, 0);
    run("divu",     3'b101, 32'd100,       32'd7,         32'd14,        34, 0, 0);
    run("remu",     3'b111, 32'd100,       32'd7,         32'd2,         34, 0, 1);
    run("divu_z",   3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1,  0, 0);
    run("remu_z",   3'b111, 32'd5,         32'd0,         32'd5,         1,  0, 0);
    run("div_z",    3'b100, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 1,  0, 0);
    run("div_ovf",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  0, 0);
    run("rem_ovf",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1,  0, 0);
    run("mul_15",   3'b000, 32'd3,         32'd5,         32'd15,        34, 0, 0);

    // flush at iteration 10
    Funct3 = 3'b000; op_a = 32'd7; op_b = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", {63'd0, busy}, 64'd0);
    saw_done = 1'b0;
    repeat (40) begin @(posedge clk); #1; saw_done |= done; end
    chk("flush_no_done", {63'd0, saw_done}, 64'd0);
    chk("flush_result", {32'd0, result}, 64'd15);

    run("start_in_calc", 3'b101, 32'd100, 32'd7, 32'd14, 34, 5, 0);

    // reset at iteration 5 of a divide
    Funct3 = 3'b100; op_a = 32'hFFFF_FFF9; op_b = 32'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    reset = 1'b1;
    #1;
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_done", {63'd0, done}, 64'd0);
    chk("midrst_result", {32'd0, result}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin @(posedge clk); #1; saw_done |= done; end
    chk("midrst_no_done", {63'd0, saw_done}, 64'd0);
    run("after_rst", 3'b101, 32'd100, 32'd7, 32'd14, 34, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and reset.
REQ-002 Parameter DATA_W SHALL default to 32, be the operand/result width, and be even and >= 8.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous active-high reset.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 Funct3  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 op_a  input  DATA_W  rs1 operand (multiplicand/dividend).
REQ-008 op_b  input  DATA_W  rs2 operand (multiplier/divisor).
REQ-009 flush  input  1  abort in-flight operation.
REQ-010 busy  output  1  high while an operation is in flight (not IDLE).
REQ-011 done  output  1  one-cycle pulse; result valid that cycle.
REQ-012 result  output  DATA_W  registered result; holds until the next done.

Function
REQ-013 States SHALL be IDLE, CALC, DONE; start=1 in IDLE latches Funct3/op_a/op_b and moves to CALC (or DONE for special cases).
REQ-014 CALC SHALL run exactly DATA_W iterations counted by a clog2(DATA_W)+1-bit counter, then move to DONE.
REQ-015 done SHALL be high exactly in the cycle after the (DATA_W+1)th rising edge following the edge that sampled start; DONE returns to IDLE on the next edge.
REQ-016 Multiply SHALL be shift-add on magnitudes into a 2*DATA_W product; signedness per op: MULH s*s, MULHSU s*u, MULHU u*u; MUL returns low half, MULH* return high half.
REQ-017 Divide SHALL be restoring on magnitudes; quotient sign = sign(a) XOR sign(b) for DIV; remainder sign = sign(a) for REM; sign correction SHALL be applied when registering result on entry to DONE.
REQ-018 Divisor zero: quotient SHALL be all ones, remainder SHALL equal op_a; goes IDLE->DONE directly (done one cycle after start sampled).
REQ-019 Signed overflow (DIV/REM, op_a = most negative, op_b = -1): quotient SHALL be op_a, remainder 0; same one-cycle path.
REQ-020 start while busy SHALL be ignored; operands of the running op SHALL NOT change.
REQ-021 flush SHALL return the FSM to IDLE on the next edge, suppress done, and leave result unchanged; flush has priority over start in the same cycle.
REQ-022 start in the same cycle as done (state DONE) SHALL be ignored; a new op is accepted only in IDLE.

Reset
REQ-023 reset SHALL asynchronously force state IDLE, counter 0, busy 0, done 0, result 0, internal operand/accumulator registers 0.
REQ-024 reset mid-operation SHALL discard the operation with no done pulse after release.

Structure
REQ-025 A shared package muldiv_pkg SHALL hold the Funct3 op enum, the FSM state typedef, and default DATA_W constant.
REQ-026 One combinational sub-module muldiv_step SHALL implement one multiply or divide iteration (add/shift vs compare/subtract/shift); FSM, counter and sign handling stay in mul_div_unit.

Verification (DATA_W=32)
REQ-027 MUL 7 * 0xFFFFFFFD -> result 0xFFFFFFEB, done exactly 33 edges after start sampled, busy high throughout.
REQ-028 MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*2 -> 0xFFFFFFFF.
REQ-029 DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-030 DIVU 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, each with done one cycle after start; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0, same latency.
REQ-031 Start MUL, assert flush at iteration 10 -> busy low next cycle, no done, result retains prior value; start pulsed during CALC -> ignored, original result returned.
REQ-032 Assert reset at iteration 5 of DIV -> busy/done/result 0 immediately; no done after release; next start completes normally.
